// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared definitions for the branch redirect controller:
//               branch opcodes and the redirect FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  // Conditional branch opcodes resolved in ID/EX
  localparam logic [5:0] OP_BEQ = 6'd4;
  localparam logic [5:0] OP_BNE = 6'd5;

  // Redirect FSM state encoding
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_e;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/branch_redirect_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones instead of wrapping.
// Ports       : clk   - clock
//               rst_n - asynchronous active-low reset, clears the count
//               inc   - increment request for this cycle
//               count - current count value
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Hold at all-ones once reached
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : branch_redirect_ctrl
// Description : Resolves BEQ/BNE compares from ID/EX, offers the branch
//               target to fetch through a valid/ready handshake, then kills
//               the IF/ID register for one cycle. Keeps saturating counts of
//               taken and not-taken branches.
// Ports       : clk, rst_n                  - clock, async active-low reset
//               br_valid/br_ready           - compare handshake from ID/EX
//               br_op, zero, pc_plus4, imm  - compare payload
//               redirect_valid/ready, _pc   - redirect handshake to fetch
//               flush_ifid                  - one-cycle IF/ID kill
//               taken_cnt, nottaken_cnt     - branch statistics
// Revision    : 1.0 - initial release
// ============================================================================
module branch_redirect_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [5:0]       br_op,
  input  logic             zero,
  input  logic [31:0]      pc_plus4,
  input  logic [31:0]      imm,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [31:0]      redirect_pc,
  output logic             flush_ifid,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] nottaken_cnt
);

  state_e      state_q;
  logic        br_ready_q;
  logic        redirect_valid_q;
  logic        flush_q;
  logic [31:0] redirect_pc_q;

  logic        accept_d;
  logic        is_beq_d;
  logic        is_bne_d;
  logic        taken_d;
  logic [31:0] target_d;

  assign accept_d = br_valid && br_ready_q;
  assign is_beq_d = (br_op == OP_BEQ);
  assign is_bne_d = (br_op == OP_BNE);
  assign taken_d  = (is_beq_d && zero) || (is_bne_d && !zero);
  // Word offset scaled to bytes; carry out of bit 31 is dropped
  assign target_d = pc_plus4 + (imm << 2);

  // FSM with outputs registered alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      br_ready_q       <= 1'b1;
      redirect_valid_q <= 1'b0;
      flush_q          <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_d) begin
            redirect_pc_q <= target_d;
          end
          if (accept_d && taken_d) begin
            state_q          <= ST_REDIRECT;
            br_ready_q       <= 1'b0;
            redirect_valid_q <= 1'b1;
          end
        end
        ST_REDIRECT: begin
          if (redirect_ready) begin
            state_q          <= ST_FLUSH;
            redirect_valid_q <= 1'b0;
            flush_q          <= 1'b1;
          end
        end
        ST_FLUSH: begin
          state_q    <= ST_IDLE;
          flush_q    <= 1'b0;
          br_ready_q <= 1'b1;
        end
        default: begin
          state_q          <= ST_IDLE;
          br_ready_q       <= 1'b1;
          redirect_valid_q <= 1'b0;
          flush_q          <= 1'b0;
        end
      endcase
    end
  end

  assign br_ready       = br_ready_q;
  assign redirect_valid = redirect_valid_q;
  assign flush_ifid     = flush_q;
  assign redirect_pc    = redirect_pc_q;

  // Only BEQ/BNE count; other opcodes are accepted and dropped
  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept_d && taken_d),
    .count (taken_cnt)
  );

  sat_counter #(.W(CNT_W)) u_nottaken_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept_d && (is_beq_d || is_bne_d) && !taken_d),
    .count (nottaken_cnt)
  );

endmodule : branch_redirect_ctrl
`default_nettype wire

// File: tb/tb_branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_redirect_ctrl
// Description : Directed scoreboard bench for branch_redirect_ctrl. Stimulus
//               pushes expected redirect targets; a monitor pops them on each
//               redirect handshake and checks the following flush pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_redirect_ctrl;

  localparam int CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic             br_valid;
  logic             br_ready;
  logic [5:0]       br_op;
  logic             zero;
  logic [31:0]      pc_plus4;
  logic [31:0]      imm;
  logic             redirect_valid;
  logic             redirect_ready;
  logic [31:0]      redirect_pc;
  logic             flush_ifid;
  logic [CNT_W-1:0] taken_cnt;
  logic [CNT_W-1:0] nottaken_cnt;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  branch_redirect_ctrl #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .br_valid       (br_valid),
    .br_ready       (br_ready),
    .br_op          (br_op),
    .zero           (zero),
    .pc_plus4       (pc_plus4),
    .imm            (imm),
    .redirect_valid (redirect_valid),
    .redirect_ready (redirect_ready),
    .redirect_pc    (redirect_pc),
    .flush_ifid     (flush_ifid),
    .taken_cnt      (taken_cnt),
    .nottaken_cnt   (nottaken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout expected=br_ready", name);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (!br_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!br_ready) timeout_fail(name);
  endtask

  // Present one compare; returns 1 time unit after the accepting edge
  task automatic do_branch(input logic [5:0] op, input logic z, input logic [31:0] pc,
                           input logic [31:0] im, input bit push, input logic [31:0] exp_pc);
    wait_idle("accept_wait");
    br_op    = op;
    zero     = z;
    pc_plus4 = pc;
    imm      = im;
    br_valid = 1'b1;
    if (push) exp_q.push_back(exp_pc);
    @(posedge clk);
    #1 br_valid = 1'b0;
  endtask

  // Monitor: pop on redirect handshake, then check the flush pulse
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && redirect_valid && redirect_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_redirect actual=0x%0h expected=none", redirect_pc);
        end else begin
          e = exp_q.pop_front();
          check("redirect_pc", redirect_pc, e);
        end
        @(negedge clk);
        check("flush_high", {31'd0, flush_ifid}, 32'd1);
        check("flush_br_ready", {31'd0, br_ready}, 32'd0);
        check("flush_rv_low", {31'd0, redirect_valid}, 32'd0);
        @(negedge clk);
        check("flush_one_cycle", {31'd0, flush_ifid}, 32'd0);
        check("idle_br_ready", {31'd0, br_ready}, 32'd1);
      end else if (flush_ifid) begin
        checks++;
        failures++;
        $display("FAIL stray_flush actual=1 expected=0");
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n          = 1'b0;
    br_valid       = 1'b0;
    br_op          = 6'd0;
    zero           = 1'b0;
    pc_plus4       = 32'd0;
    imm            = 32'd0;
    redirect_ready = 1'b1;

    // Reset state
    #12;
    check("rst_rv", {31'd0, redirect_valid}, 32'd0);
    check("rst_flush", {31'd0, flush_ifid}, 32'd0);
    check("rst_pc", redirect_pc, 32'd0);
    check("rst_taken", {30'd0, taken_cnt}, 32'd0);
    check("rst_nottaken", {30'd0, nottaken_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("rst_br_ready", {31'd0, br_ready}, 32'd1);

    // BEQ taken: 0x100 + (3<<2) = 0x10C
    do_branch(6'd4, 1'b1, 32'h100, 32'h3, 1'b1, 32'h10C);
    check("beq_latency_rv", {31'd0, redirect_valid}, 32'd1);
    check("beq_br_ready_low", {31'd0, br_ready}, 32'd0);
    wait_idle("beq_idle");
    check("beq_taken_cnt", {30'd0, taken_cnt}, 32'd1);

    // BNE not-taken then illegal op, back-to-back
    do_branch(6'd5, 1'b1, 32'h300, 32'h10, 1'b0, 32'd0);
    check("bne_nt_br_ready", {31'd0, br_ready}, 32'd1);
    check("bne_nt_rv", {31'd0, redirect_valid}, 32'd0);
    do_branch(6'd6, 1'b0, 32'h400, 32'h10, 1'b0, 32'd0);
    check("illegal_br_ready", {31'd0, br_ready}, 32'd1);
    check("illegal_rv", {31'd0, redirect_valid}, 32'd0);
    check("nt_nottaken_cnt", {30'd0, nottaken_cnt}, 32'd1);
    check("nt_taken_cnt", {30'd0, taken_cnt}, 32'd1);

    // Backpressure: BNE taken, 0x200 + (-1<<2) = 0x1FC
    redirect_ready = 1'b0;
    do_branch(6'd5, 1'b0, 32'h200, 32'hFFFF_FFFF, 1'b1, 32'h1FC);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_rv_held", {31'd0, redirect_valid}, 32'd1);
      check("bp_pc_held", redirect_pc, 32'h1FC);
      check("bp_br_ready", {31'd0, br_ready}, 32'd0);
    end
    @(posedge clk);
    #1 redirect_ready = 1'b1;
    wait_idle("bp_idle");
    check("bp_taken_cnt", {30'd0, taken_cnt}, 32'd2);

    // Wrap-around target
    do_branch(6'd4, 1'b1, 32'hFFFF_FFFC, 32'h1, 1'b1, 32'h0);
    wait_idle("wrap_idle");
    check("wrap_taken_cnt", {30'd0, taken_cnt}, 32'd3);

    // Saturation: two more taken branches keep the count at 3
    do_branch(6'd4, 1'b1, 32'h0, 32'h0, 1'b1, 32'h0);
    wait_idle("sat1_idle");
    do_branch(6'd5, 1'b0, 32'h20, 32'h2, 1'b1, 32'h28);
    wait_idle("sat2_idle");
    check("sat_taken_cnt", {30'd0, taken_cnt}, 32'd3);
    check("sat_nottaken_cnt", {30'd0, nottaken_cnt}, 32'd1);

    // Reset mid-REDIRECT
    redirect_ready = 1'b0;
    do_branch(6'd4, 1'b1, 32'h80, 32'h1, 1'b1, 32'h84);
    check("pre_rst_rv", {31'd0, redirect_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_rv", {31'd0, redirect_valid}, 32'd0);
    check("mid_rst_flush", {31'd0, flush_ifid}, 32'd0);
    check("mid_rst_pc", redirect_pc, 32'd0);
    check("mid_rst_taken", {30'd0, taken_cnt}, 32'd0);
    check("mid_rst_nottaken", {30'd0, nottaken_cnt}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n          = 1'b1;
    redirect_ready = 1'b1;

    // Normal operation after reset release
    do_branch(6'd4, 1'b1, 32'h40, 32'h4, 1'b1, 32'h50);
    wait_idle("post_rst_idle");
    check("post_rst_taken", {30'd0, taken_cnt}, 32'd1);
    check("post_rst_nottaken", {30'd0, nottaken_cnt}, 32'd0);
    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_branch_redirect_ctrl
`default_nettype wire
